seg_scan_decoder: RTL and testbench

Recovers the four hex nibbles shown on the multiplexed 7-segment display by watching the active-low anode and segment lines (`an`, `seg`) that the display driver produces. It decodes each stable digit dwell back to a nibble and assembles a full frame once all four positions have been seen. It presents the frame on a valid/ready handshake. It sits beside the display driver as an in-fabric self-check and debug monitor, and can also be instantiated in benches.

---
 rtl/seg_scan_decoder_if.sv | 19 +
 rtl/seg_scan_decoder.sv | 155 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Frame handshake between the scan decoder (master) and whatever consumes
// the recovered 16-bit display frames (slave).
interface seg_scan_decoder_if;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed 7-segment display's anode/segment lines, decodes each
// stable digit dwell to a hex nibble and hands out complete 4-digit frames.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       btnC,
  input  logic [3:0]                 an,
  input  logic [6:0]                 seg,
  seg_scan_decoder_if.master         frame,
  output logic                       overrun,
  output logic                       err_seg,
  output logic                       err_an
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  logic [3:0]  an_p0;
  logic [6:0]  seg_p0;
  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap;
  logic        match;
  logic        an_ok;
  logic [1:0]  an_idx;
  logic [4:0]  dec;
  logic        rec;
  logic [3:0]  seen, seen_nxt;
  logic [15:0] shadow;
  logic        complete;
  logic        slot_free;

  // Stage p0: sample register; reset to blank so a dwell held across reset starts over
  always_ff @(posedge clk) begin
    if (btnC) begin
      an_p0  <= 4'hF;
      seg_p0 <= 7'h7F;
    end else begin
      an_p0  <= an;
      seg_p0 <= seg;
    end
  end

  assign match = (an == an_p0) && (seg == seg_p0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    if (!match) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (an != 4'hF) begin
            cnt_nxt = 4'd1;
            if (STABLE_N <= 4'd1) begin
              cap       = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt_nxt = cnt + 4'd1;
          if (cnt + 4'd1 >= STABLE_N) begin
            cap       = 1'b1;
            state_nxt = HELD;
          end
        end
        HELD:    state_nxt = HELD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    an_ok  = 1'b1;
    an_idx = 2'd0;
    case (an_p0)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_ok  = 1'b0;
    endcase
  end

  assign dec       = seg_decode(seg_p0);
  assign rec       = cap && an_ok && dec[4];
  assign complete  = (seen == 4'hF);
  assign slot_free = !frame.frame_valid || frame.frame_ready;

  // Completion clears seen; a capture on the same edge would still be kept
  always_comb begin
    seen_nxt = complete ? 4'h0 : seen;
    if (rec) seen_nxt[an_idx] = 1'b1;
  end

  // Stage p1: capture, frame assembly and output slot
  always_ff @(posedge clk) begin
    if (btnC) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      seen              <= 4'h0;
      shadow            <= 16'h0000;
      frame.frame_data  <= 16'h0000;
      frame.frame_valid <= 1'b0;
      overrun           <= 1'b0;
      err_seg           <= 1'b0;
      err_an            <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      seen  <= seen_nxt;
      if (rec) shadow[{an_idx, 2'b00} +: 4] <= dec[3:0];
      if (cap && !an_ok) err_an <= 1'b1;
      if (cap && an_ok && !dec[4]) err_seg <= 1'b1;
      if (complete && slot_free) begin
        frame.frame_data  <= shadow;
        frame.frame_valid <= 1'b1;
      end else if (frame.frame_valid && frame.frame_ready) begin
        frame.frame_valid <= 1'b0;
      end
      if (complete && !slot_free) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and scenario-driven bench for seg_scan_decoder; two instances
// (settle windows 1 and 3) are checked every edge against a dwell-level model.
module tb_seg_scan_decoder;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam int S_OF [2] = '{1, 3};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] an;
  logic [6:0] seg;
  logic       rdy;
  logic       ovr0, es0, ea0, ovr1, es1, ea1;

  int total = 0;
  int bad   = 0;

  seg_scan_decoder_if fif0 ();
  seg_scan_decoder_if fif1 ();

  assign fif0.frame_ready = rdy;
  assign fif1.frame_ready = rdy;

  seg_scan_decoder #(.STABLE_CYCLES(1)) dut0 (
    .clk(clk), .btnC(rst), .an(an), .seg(seg), .frame(fif0),
    .overrun(ovr0), .err_seg(es0), .err_an(ea0)
  );

  seg_scan_decoder #(.STABLE_CYCLES(3)) dut1 (
    .clk(clk), .btnC(rst), .an(an), .seg(seg), .frame(fif1),
    .overrun(ovr1), .err_seg(es1), .err_an(ea1)
  );

  always #5 clk = ~clk;

  // Reference model state: dwell tracking is shared, the rest is per instance
  int         edge_n = 0;
  int         dwell_start = 0;
  logic [3:0] prev_an = 4'hF;
  logic [6:0] prev_seg = 7'h7F;
  logic [3:0] m_sh   [2][4];
  logic [3:0] m_seen [2];
  logic       m_v    [2];
  logic [15:0] m_data[2];
  logic       m_ovr  [2];
  logic       m_es   [2];
  logic       m_ea   [2];
  logic       saw_e853 = 1'b0;
  logic       saw_f0a1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) m_sh[i][j] = 4'h0;
      m_seen[i] = 4'h0;
      m_v[i]    = 1'b0;
      m_data[i] = 16'h0000;
      m_ovr[i]  = 1'b0;
      m_es[i]   = 1'b0;
      m_ea[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    int k;
    int d;
    edge_n++;
    if (rst) begin
      model_reset();
      prev_an  = 4'hF;
      prev_seg = 7'h7F;
      return;
    end
    if (an != prev_an || seg != prev_seg) dwell_start = edge_n;
    prev_an  = an;
    prev_seg = seg;
    for (int i = 0; i < 2; i++) begin
      if (m_seen[i] == 4'hF) begin
        if (!m_v[i] || rdy) begin
          m_data[i] = {m_sh[i][3], m_sh[i][2], m_sh[i][1], m_sh[i][0]};
          m_v[i]    = 1'b1;
        end else begin
          m_ovr[i] = 1'b1;
        end
        m_seen[i] = 4'h0;
      end else if (m_v[i] && rdy) begin
        m_v[i] = 1'b0;
      end
      if (an != 4'hF && edge_n == dwell_start + S_OF[i]) begin
        k = -1;
        for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) k = j;
        if (k < 0) m_ea[i] = 1'b1;
        else begin
          d = -1;
          for (int n = 0; n < 16; n++) if (SEG_TBL[n] == seg) d = n;
          if (d < 0) m_es[i] = 1'b1;
          else begin
            m_sh[i][k]   = 4'(d);
            m_seen[i][k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (fif0.frame_valid && fif0.frame_data == 16'hE853) saw_e853 = 1'b1;
    if (fif0.frame_valid && fif0.frame_data == 16'hF0A1) saw_f0a1 = 1'b1;
    chk("valid0",   32'(fif0.frame_valid), 32'(m_v[0]));
    chk("data0",    32'(fif0.frame_data),  32'(m_data[0]));
    chk("overrun0", 32'(ovr0),             32'(m_ovr[0]));
    chk("err_seg0", 32'(es0),              32'(m_es[0]));
    chk("err_an0",  32'(ea0),              32'(m_ea[0]));
    chk("valid1",   32'(fif1.frame_valid), 32'(m_v[1]));
    chk("data1",    32'(fif1.frame_data),  32'(m_data[1]));
    chk("overrun1", 32'(ovr1),             32'(m_ovr[1]));
    chk("err_seg1", 32'(es1),              32'(m_es[1]));
    chk("err_an1",  32'(ea1),              32'(m_ea[1]));
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int len);
    an  = a;
    seg = s;
    for (int i = 0; i < len; i++) tick();
  endtask

  task automatic digit(input int k, input int nib, input int len);
    show(~(4'b0001 << k), SEG_TBL[nib], len);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic scan(input int r, input int rc, input int lc, input int l, input int len);
    digit(0, r, len);
    digit(1, rc, len);
    digit(2, lc, len);
    digit(3, l, len);
  endtask

  initial begin
    int len;
    logic [3:0] a;
    logic [6:0] s;
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    rdy = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_valid", 32'(fif0.frame_valid), 32'd0);
    chk("reset_data",  32'(fif0.frame_data),  32'd0);
    rst = 1'b0;

    // basic frame with ready held high
    rdy = 1'b1;
    scan(3, 5, 8, 14, 2);
    show(4'hF, 7'h7F, 3);
    chk("plan_e853_seen", 32'(saw_e853), 32'd1);

    // consumer stalled, second frame overruns, then drains
    rdy = 1'b0;
    scan(3, 5, 8, 14, 2);
    show(4'hF, 7'h7F, 2);
    scan(0, 0, 0, 0, 2);
    show(4'hF, 7'h7F, 3);
    chk("plan_held_data", 32'(fif0.frame_data), 32'hE853);
    chk("plan_overrun",   32'(ovr0),            32'd1);
    rdy = 1'b1;
    show(4'hF, 7'h7F, 3);
    pulse_reset();

    // one-edge dwell on RC is ignored until re-shown
    digit(0, 1, 2);
    digit(1, 2, 1);
    digit(2, 3, 2);
    digit(3, 4, 2);
    show(4'hF, 7'h7F, 2);
    digit(1, 2, 2);
    show(4'hF, 7'h7F, 3);

    // bad segment pattern and bad anode value
    show(4'b1011, 7'h7F, 4);
    show(4'b1100, 7'h00, 4);
    pulse_reset();

    // blanks interleaved between digits
    digit(0, 1, 2);  show(4'hF, 7'h7F, 2);
    digit(1, 10, 2); show(4'hF, 7'h7F, 1);
    digit(2, 0, 2);  show(4'hF, 7'h00, 2);
    digit(3, 15, 2); show(4'hF, 7'h7F, 3);
    chk("plan_f0a1_seen", 32'(saw_f0a1), 32'd1);

    // reset after three digits discards partial frame
    digit(0, 7, 4);
    digit(1, 6, 4);
    digit(2, 9, 4);
    pulse_reset();
    digit(3, 2, 4);
    show(4'hF, 7'h7F, 4);
    chk("plan_no_frame", 32'(fif0.frame_valid), 32'd0);

    // randomized dwells
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 4'hF;
        1:       a = 4'($urandom);
        default: a = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      s   = ($urandom_range(0, 11) == 0) ? 7'($urandom) : SEG_TBL[$urandom_range(0, 15)];
      len = $urandom_range(1, 6);
      an  = a;
      seg = s;
      for (int i = 0; i < len; i++) begin
        rdy = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
